// File: rtl/filt_writer.sv
// Buffers filtered pixels in a small FIFO and writes them to the filtered-image
// memory, stepping the address across the valid (OUT_SIZE x OUT_SIZE) window.
module filt_writer #(
  parameter int unsigned IMG_SIZE   = 256,
  parameter int unsigned KER_SIZE   = 3,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OUT_SIZE = IMG_SIZE - KER_SIZE + 1;
  localparam int unsigned TOTAL    = OUT_SIZE * OUT_SIZE;
  localparam int unsigned CW       = $clog2(TOTAL + 1);
  localparam int unsigned RCW      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [CW-1:0]     in_cnt;
  logic [RCW-1:0]    row;
  logic [RCW-1:0]    col;
  logic [15:0]       addr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              last_col;
  logic              last_wr;

  // Extra pointer bit distinguishes full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready  = (state == RUN) && !fifo_full && (in_cnt < CW'(TOTAL));
  assign mem_we    = (state == RUN) && !fifo_empty;
  assign mem_wdata = fifo_mem[rd_ptr[AW-1:0]];
  assign mem_addr  = addr;

  assign push     = in_valid && in_ready;
  assign pop      = mem_we && mem_ready;
  assign last_col = (col == RCW'(OUT_SIZE - 1));
  assign last_wr  = last_col && (row == RCW'(OUT_SIZE - 1));

  // Frame control, FIFO pointers and address walker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      in_cnt <= '0;
      row    <= '0;
      col    <= '0;
      addr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[AW'(i)] <= '0;
    end else begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= in_data;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            done   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            in_cnt <= '0;
            row    <= '0;
            col    <= '0;
            addr   <= '0;
          end
        end
        RUN: begin
          if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            in_cnt <= in_cnt + 1'b1;
          end
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            // Final write freezes the address; row end skips the kernel margin.
            if (last_wr) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (last_col) begin
              col  <= '0;
              row  <= row + 1'b1;
              addr <= addr + 16'(KER_SIZE);
            end else begin
              col  <= col + 1'b1;
              addr <= addr + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filt_writer.sv
// Scoreboard bench for filt_writer at IMG_SIZE=6, KER_SIZE=3 (4x4 output window).
module tb_filt_writer;

  localparam int IMG = 6;
  localparam int KER = 3;
  localparam int OUT = IMG - KER + 1;
  localparam int TOT = OUT * OUT;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  filt_writer #(.IMG_SIZE(IMG), .KER_SIZE(KER), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];
  logic [23:0] act_q[$];
  int acc_k;
  int wr_k;
  logic s_push, s_pop, s_we, s_rdy;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;

  function automatic logic [15:0] model_addr(int k);
    return 16'((k / OUT) * IMG + (k % OUT));
  endfunction

  // One clock: sample at the falling edge, record transfers, return at posedge+1.
  task automatic step();
    @(negedge clk);
    s_push  = in_valid && in_ready;
    s_pop   = mem_we && mem_ready;
    s_we    = mem_we;
    s_rdy   = in_ready;
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
    if (s_push) begin
      exp_q.push_back({model_addr(acc_k), in_data});
      acc_k++;
    end
    if (s_pop) begin
      act_q.push_back({mem_addr, mem_wdata});
      wr_k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    exp_q.delete();
    act_q.delete();
    acc_k = 0;
    wr_k  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Keeps in_valid high with incrementing data until done or budget expiry.
  task automatic run_frame(input logic [7:0] base, input bit toggle, output int cyc);
    cyc = 0;
    in_valid = 1'b1;
    while (!done && cyc < 200) begin
      in_data   = base + 8'(acc_k);
      mem_ready = toggle ? 1'(cyc % 2) : 1'b1;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; mem_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, mem_we, busy, done, mem_addr, mem_wdata} !== 28'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b we=%b busy=%b done=%b addr=%0d wdata=%h, expected all 0",
               in_ready, mem_we, busy, done, mem_addr, mem_wdata);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1;
    step(); step();
    n_cmp++;
    if ({s_rdy, s_we, busy, done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got rdy=%b we=%b busy=%b done=%b, expected 0000", s_rdy, s_we, busy, done);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    logic [23:0] a, e;
    mem_ready = 1'b1;
    do_start();
    n_cmp++;
    if ({busy, done, in_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL basic_run_entry: got busy=%b done=%b rdy=%b, expected 1 0 1", busy, done, in_ready);
    end
    run_frame(8'h10, 1'b0, cyc);
    n_cmp++;
    if (cyc != TOT + 1) begin
      n_bad++; $display("FAIL basic_latency: got %0d cycles to done, expected %0d", cyc, TOT + 1);
    end
    n_cmp++;
    if ({done, busy} !== 2'b10 || acc_k != TOT) begin
      n_bad++; $display("FAIL basic_done: got done=%b busy=%b accepted=%0d, expected 1 0 %0d", done, busy, acc_k, TOT);
    end
    n_cmp++;
    if (act_q.size() != TOT) begin
      n_bad++; $display("FAIL basic_count: got %0d writes, expected %0d", act_q.size(), TOT);
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL basic_write: got addr %0d data %h, expected addr %0d data %h", a[23:8], a[7:0], e[23:8], e[7:0]);
      end
    end
  endtask

  task automatic test_stall();
    int cyc;
    bit stable, got_ref;
    logic [15:0] ref_addr;
    logic [7:0]  ref_data;
    logic [23:0] a, e;
    do_start();
    mem_ready = 1'b0; in_valid = 1'b1; stable = 1'b1; got_ref = 1'b0;
    ref_addr = '0; ref_data = '0;
    for (int c = 0; c < 10; c++) begin
      in_data = 8'h40 + 8'(acc_k);
      step();
      if (s_we) begin
        if (!got_ref) begin ref_addr = s_addr; ref_data = s_wdata; got_ref = 1'b1; end
        else if (s_addr !== ref_addr || s_wdata !== ref_data) stable = 1'b0;
      end
    end
    n_cmp++;
    if (acc_k != 4) begin n_bad++; $display("FAIL stall_accepted: got %0d pixels, expected 4", acc_k); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got in_ready=%b, expected 0", in_ready); end
    n_cmp++;
    if (!(stable && got_ref) || {ref_addr, ref_data} !== {16'd0, 8'h40}) begin
      n_bad++;
      $display("FAIL stall_hold: got stable=%b seen=%b addr %0d data %h, expected stable addr 0 data 40",
               stable, got_ref, ref_addr, ref_data);
    end
    run_frame(8'h40, 1'b0, cyc);
    n_cmp++;
    if (done !== 1'b1 || act_q.size() != TOT) begin
      n_bad++; $display("FAIL stall_resume: got done=%b writes=%0d, expected 1 %0d", done, act_q.size(), TOT);
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL stall_write: got addr %0d data %h, expected addr %0d data %h", a[23:8], a[7:0], e[23:8], e[7:0]);
      end
    end
  endtask

  task automatic test_toggle();
    int cyc;
    logic [23:0] a, e;
    do_start();
    run_frame(8'hA0, 1'b1, cyc);
    n_cmp++;
    if (done !== 1'b1 || acc_k != TOT || act_q.size() != TOT || exp_q.size() != TOT) begin
      n_bad++;
      $display("FAIL toggle_count: got done=%b accepted=%0d writes=%0d, expected 1 %0d %0d", done, acc_k, act_q.size(), TOT, TOT);
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL toggle_write: got addr %0d data %h, expected addr %0d data %h", a[23:8], a[7:0], e[23:8], e[7:0]);
      end
    end
  endtask

  task automatic test_rst_mid();
    int cyc;
    bit leaked;
    logic [23:0] a, e;
    do_start();
    mem_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 50 && wr_k < 7; c++) begin
      in_data = 8'h60 + 8'(acc_k);
      step();
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, mem_we, busy, done, mem_addr, mem_wdata} !== 28'd0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got rdy=%b we=%b busy=%b done=%b addr=%0d wdata=%h, expected all 0",
               in_ready, mem_we, busy, done, mem_addr, mem_wdata);
    end
    n_cmp++;
    if (act_q.size() != 7) begin n_bad++; $display("FAIL midrst_pre: got %0d writes, expected 7", act_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL midrst_pre_write: got addr %0d data %h, expected addr %0d data %h", a[23:8], a[7:0], e[23:8], e[7:0]);
      end
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    leaked = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (s_we || s_rdy) leaked = 1'b1;
    end
    n_cmp++;
    if (leaked) begin n_bad++; $display("FAIL midrst_idle: got activity before start, expected none"); end
    do_start();
    run_frame(8'h70, 1'b1, cyc);
    n_cmp++;
    if (done !== 1'b1 || act_q.size() != TOT) begin
      n_bad++; $display("FAIL midrst_frame: got done=%b writes=%0d, expected 1 %0d", done, act_q.size(), TOT);
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL midrst_write: got addr %0d data %h, expected addr %0d data %h", a[23:8], a[7:0], e[23:8], e[7:0]);
      end
    end
  endtask

  task automatic test_start_ignore();
    int cyc;
    bit active;
    logic [23:0] a, e;
    do_start();
    mem_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_data = 8'h80 + 8'(acc_k);
      step();
    end
    start = 1'b1;
    in_data = 8'h80 + 8'(acc_k);
    step();
    start = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_bad++; $display("FAIL start_in_run: got busy=%b done=%b, expected 1 0", busy, done);
    end
    run_frame(8'h80, 1'b0, cyc);
    n_cmp++;
    if (done !== 1'b1 || acc_k != TOT || act_q.size() != TOT) begin
      n_bad++;
      $display("FAIL ignore_count: got done=%b accepted=%0d writes=%0d, expected 1 %0d %0d", done, acc_k, act_q.size(), TOT, TOT);
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL ignore_write: got addr %0d data %h, expected addr %0d data %h", a[23:8], a[7:0], e[23:8], e[7:0]);
      end
    end
    in_valid = 1'b1; active = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (s_rdy || s_we || !done) active = 1'b1;
    end
    n_cmp++;
    if (active) begin n_bad++; $display("FAIL done_hold: got accept/write or done drop in DONE, expected none"); end
    do_start();
    n_cmp++;
    if ({busy, done, mem_addr} !== {2'b10, 16'd0}) begin
      n_bad++; $display("FAIL restart: got busy=%b done=%b addr=%0d, expected 1 0 0", busy, done, mem_addr);
    end
    run_frame(8'h90, 1'b0, cyc);
    n_cmp++;
    if (done !== 1'b1 || act_q.size() != TOT) begin
      n_bad++; $display("FAIL restart_frame: got done=%b writes=%0d, expected 1 %0d", done, act_q.size(), TOT);
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL restart_write: got addr %0d data %h, expected addr %0d data %h", a[23:8], a[7:0], e[23:8], e[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_toggle();
    test_rst_mid();
    test_start_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
